// File: rtl/mem_responder_if.sv
// Request/response bus between the data-movement unit and the memory responder.
// The master drives requests and consumes responses; the slave services them.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  read;
    logic [1:0]  write;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, read, write, mem_addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, read, write, mem_addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/mem_responder.sv
// Services LDW/STW memory request codes against a word-addressed data RAM,
// with a programmable wait-state phase and a held response.
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int         DATA_W   = 32;
    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;

    logic                  store_p0;
    logic                  illegal_p0;
    logic [31:0]           addr_p0;
    logic [DATA_W-1:0]     wdata_p0;

    logic [DATA_W-1:0]     ram [DEPTH];
    logic [DATA_W-1:0]     rdata_p1;
    logic                  err_p1;

    logic                  ld_code, st_code, accept, consume, enter_resp;
    logic                  cmt_store, cmt_illegal, cmt_err;
    logic [31:0]           cmt_addr;
    logic [DATA_W-1:0]     cmt_wdata;
    logic [ADDR_BITS-1:0]  cmt_idx;

    function automatic logic out_of_range(input logic [31:0] a);
        return (a >> ADDR_BITS) != 32'd0;
    endfunction

    always_comb begin
        ld_code = (bus.read == 2'b01);
        st_code = (bus.write == 2'b01);
        accept  = (state == S_IDLE) && bus.req_valid && (ld_code || st_code);
        consume = (state == S_RESP) && bus.rsp_ready;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        enter_resp   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_nxt = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == LAST_CNT) begin
                    state_nxt    = S_RESP;
                    enter_resp   = 1'b1;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so the
    // commit must see the live request rather than the latched copy.
    always_comb begin
        if (state == S_IDLE) begin
            cmt_store   = st_code && !ld_code;
            cmt_illegal = st_code && ld_code;
            cmt_addr    = bus.mem_addr;
            cmt_wdata   = bus.wdata;
        end else begin
            cmt_store   = store_p0;
            cmt_illegal = illegal_p0;
            cmt_addr    = addr_p0;
            cmt_wdata   = wdata_p0;
        end
        cmt_err = cmt_illegal || out_of_range(cmt_addr);
        cmt_idx = cmt_addr[ADDR_BITS-1:0];
    end

    // p0: request captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            store_p0   <= st_code && !ld_code;
            illegal_p0 <= st_code && ld_code;
            addr_p0    <= bus.mem_addr;
            wdata_p0   <= bus.wdata;
        end
    end

    // p1: commit into RAM; a store is dropped if reset is held over its commit edge
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cmt_store && !cmt_err)
            ram[cmt_idx] <= cmt_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (enter_resp) begin
                err_p1   <= cmt_err;
                rdata_p1 <= (!cmt_store && !cmt_err) ? ram[cmt_idx] : '0;
            end else if (consume) begin
                err_p1   <= 1'b0;
                rdata_p1 <= '0;
            end
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rdata     = rdata_p1;
    assign bus.err       = err_p1;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing clock and reset.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_responder_if ba();
    mem_responder_if bz();

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ba)
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        ba.req_valid = rv;
        ba.read      = rd;
        ba.write     = wr;
        ba.mem_addr  = addr;
        ba.wdata     = wd;
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance with rsp_ready high.
    task automatic xact(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rdata);
        drive(1'b1, rd, wr, addr, wd);
        chk({tag, ".req_ready_idle"}, ba.req_ready, 1);
        tick();
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk({tag, ".wait0_rsp_valid"}, ba.rsp_valid, 0);
        chk({tag, ".wait0_req_ready"}, ba.req_ready, 0);
        tick();
        chk({tag, ".wait1_rsp_valid"}, ba.rsp_valid, 0);
        tick();
        chk({tag, ".rsp_valid"}, ba.rsp_valid, 1);
        chk({tag, ".err"}, ba.err, exp_err);
        chk({tag, ".rdata"}, ba.rdata, exp_rdata);
        tick();
        chk({tag, ".done_rsp_valid"}, ba.rsp_valid, 0);
        chk({tag, ".done_req_ready"}, ba.req_ready, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        ba.rsp_ready = 1'b1;
        bz.req_valid = 1'b0;
        bz.read      = 2'b00;
        bz.write     = 2'b00;
        bz.mem_addr  = 32'h0;
        bz.wdata     = 32'h0;
        bz.rsp_ready = 1'b1;

        #2;
        chk("reset.req_ready", ba.req_ready, 1);
        chk("reset.rsp_valid", ba.rsp_valid, 0);
        chk("reset.rdata", ba.rdata, 0);
        chk("reset.err", ba.err, 0);
        chk("reset.z_req_ready", bz.req_ready, 1);
        chk("reset.z_rsp_valid", bz.rsp_valid, 0);
        tick();
        tick();
        rst = 1'b0;

        xact("st05", 2'b00, 2'b01, 32'h05, 32'hDEADBEEF, 1'b0, 32'h0);

        // Load with backpressure; request inputs wiggle after accept.
        ba.rsp_ready = 1'b0;
        drive(1'b1, 2'b01, 2'b00, 32'h05, 32'h0);
        tick();
        drive(1'b1, 2'b00, 2'b01, 32'h00, 32'hFFFFFFFF);
        tick();
        tick();
        chk("bp.rsp_valid", ba.rsp_valid, 1);
        chk("bp.rdata", ba.rdata, 32'hDEADBEEF);
        chk("bp.err", ba.err, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.hold_rsp_valid", ba.rsp_valid, 1);
            chk("bp.hold_rdata", ba.rdata, 32'hDEADBEEF);
            chk("bp.hold_err", ba.err, 0);
            chk("bp.hold_req_ready", ba.req_ready, 0);
        end
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        ba.rsp_ready = 1'b1;
        tick();
        chk("bp.done_rsp_valid", ba.rsp_valid, 0);
        chk("bp.done_req_ready", ba.req_ready, 1);
        chk("bp.done_rdata", ba.rdata, 0);

        xact("st00", 2'b00, 2'b01, 32'h00, 32'hA5A50000, 1'b0, 32'h0);
        xact("illegal", 2'b01, 2'b01, 32'h00, 32'h22222222, 1'b1, 32'h0);
        xact("st_oor", 2'b00, 2'b01, 32'h100, 32'h11111111, 1'b1, 32'h0);
        xact("ld_oor", 2'b01, 2'b00, 32'hFFFFFF05, 32'h0, 1'b1, 32'h0);
        xact("ld00", 2'b01, 2'b00, 32'h00, 32'h0, 1'b0, 32'hA5A50000);
        xact("ld05_wr_other", 2'b01, 2'b10, 32'h05, 32'h0, 1'b0, 32'hDEADBEEF);

        // Non-memory codes are ignored.
        drive(1'b1, 2'b10, 2'b10, 32'h05, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nonmem.req_ready", ba.req_ready, 1);
            chk("nonmem.rsp_valid", ba.rsp_valid, 0);
        end
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);

        // Reset during WAIT held over the commit edge: store must not land.
        xact("st07_old", 2'b00, 2'b01, 32'h07, 32'h0BADF00D, 1'b0, 32'h0);
        drive(1'b1, 2'b00, 2'b01, 32'h07, 32'h12345678);
        tick();
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait.rsp_valid", ba.rsp_valid, 0);
        chk("rstwait.req_ready", ba.req_ready, 1);
        chk("rstwait.err", ba.err, 0);
        tick();
        rst = 1'b0;
        chk("rstwait.after_rsp_valid", ba.rsp_valid, 0);
        tick();
        chk("rstwait.idle_rsp_valid", ba.rsp_valid, 0);
        xact("ld07", 2'b01, 2'b00, 32'h07, 32'h0, 1'b0, 32'h0BADF00D);

        // Reset during a held response drops it asynchronously.
        ba.rsp_ready = 1'b0;
        drive(1'b1, 2'b01, 2'b00, 32'h05, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        tick();
        chk("rstresp.pre_rsp_valid", ba.rsp_valid, 1);
        chk("rstresp.pre_rdata", ba.rdata, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("rstresp.rsp_valid", ba.rsp_valid, 0);
        chk("rstresp.rdata", ba.rdata, 0);
        chk("rstresp.req_ready", ba.req_ready, 1);
        tick();
        rst = 1'b0;
        ba.rsp_ready = 1'b1;

        // Zero wait states: response right after accept, accepts every 2 cycles.
        bz.req_valid = 1'b1;
        bz.read      = 2'b00;
        bz.write     = 2'b01;
        bz.mem_addr  = 32'h03;
        bz.wdata     = 32'hCAFEF00D;
        tick();
        chk("z.st_rsp_valid", bz.rsp_valid, 1);
        chk("z.st_err", bz.err, 0);
        chk("z.st_rdata", bz.rdata, 0);
        chk("z.st_req_ready", bz.req_ready, 0);
        bz.read  = 2'b01;
        bz.write = 2'b00;
        tick();
        chk("z.consume_rsp_valid", bz.rsp_valid, 0);
        chk("z.consume_req_ready", bz.req_ready, 1);
        tick();
        chk("z.ld_rsp_valid", bz.rsp_valid, 1);
        chk("z.ld_rdata", bz.rdata, 32'hCAFEF00D);
        bz.req_valid = 1'b0;
        tick();
        chk("z.done_rsp_valid", bz.rsp_valid, 0);
        chk("z.done_rdata", bz.rdata, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
